id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage core.
- Captures decoded operands and control from ID and presents them to EX; its exRs1/exRs2 outputs drive the EX-stage forwarding logic's rs1/rs2 inputs.
- On a load-use hazard it stalls PC and IF/ID for one cycle and inserts a bubble into EX.
- Also honours a branch flush from EX and a global memory hold.

---
 rtl/id_ex_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register for the 5-stage core, with load-use hazard
//   detection built in.
//
//   Each rising edge the register does one of the following, first match wins:
//     memHold -> keep every register (the whole pipeline is frozen)
//     flush   -> load a bubble (kill the instruction entering EX)
//     loadUse -> load a bubble; stallIfId holds PC and IF/ID so the same
//                ID instruction is re-presented on the next cycle
//     else    -> capture all id* fields, exValid <= idValid
//
//   Stall handshake: stallIfId is combinational. While it is high, the
//   upstream stages must not advance, and this stage does not consume the ID
//   instruction. A load-use stall lasts exactly one cycle, because the bubble
//   it inserts removes the load from EX.
//
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     memHold, flush               global freeze, branch/jump kill from EX
//     idValid, idRs1/2, idRd       decoded instruction from ID
//     idUsesRs1/2                  the instruction really reads rs1/rs2
//     idRs1Data, idRs2Data,        operands, immediate and PC (XLEN bits)
//       idImm, idPc
//     idAluOp, idAluSrc, idMemRead, idMemWrite, idRegWrite, idMemToReg,
//       idBranch                   control bits
//     ex*                          registered copies presented to EX
//     stallIfId                    hold PC and IF/ID this cycle
//
//   Optional build macro HAZARD_PERF_CNT_EN adds two 32-bit saturating
//   counters: bubbleCount (load-use bubbles) and flushCount (flush bubbles).
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memHold,
  input  logic               flush,
  input  logic               idValid,
  input  logic [4:0]         idRs1,
  input  logic [4:0]         idRs2,
  input  logic [4:0]         idRd,
  input  logic               idUsesRs1,
  input  logic               idUsesRs2,
  input  logic [XLEN-1:0]    idRs1Data,
  input  logic [XLEN-1:0]    idRs2Data,
  input  logic [XLEN-1:0]    idImm,
  input  logic [XLEN-1:0]    idPc,
  input  logic [ALUOP_W-1:0] idAluOp,
  input  logic               idAluSrc,
  input  logic               idMemRead,
  input  logic               idMemWrite,
  input  logic               idRegWrite,
  input  logic               idMemToReg,
  input  logic               idBranch,
  output logic               exValid,
  output logic [4:0]         exRs1,
  output logic [4:0]         exRs2,
  output logic [4:0]         exRd,
  output logic [XLEN-1:0]    exRs1Data,
  output logic [XLEN-1:0]    exRs2Data,
  output logic [XLEN-1:0]    exImm,
  output logic [XLEN-1:0]    exPc,
  output logic [ALUOP_W-1:0] exAluOp,
  output logic               exAluSrc,
  output logic               exMemRead,
  output logic               exMemWrite,
  output logic               exRegWrite,
  output logic               exMemToReg,
  output logic               exBranch,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]        bubbleCount,
  output logic [31:0]        flushCount,
`endif
  output logic               stallIfId
);

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // The load in EX only produces its data in MEM, so a dependent instruction
  // in ID must wait one cycle. A load to x0 never creates a dependency.
  assign rs1_hit  = idUsesRs1 && (idRs1 == exRd);
  assign rs2_hit  = idUsesRs2 && (idRs2 == exRd);
  assign load_use = exValid && exMemRead && (exRd != 5'd0) && idValid &&
                    (rs1_hit || rs2_hit);

  // memHold already freezes upstream, and a flush kills the dependent
  // instruction anyway, so neither needs a separate stall.
  assign stallIfId = load_use && !flush && !memHold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid    <= 1'b0;
      exRs1      <= '0;
      exRs2      <= '0;
      exRd       <= '0;
      exRs1Data  <= '0;
      exRs2Data  <= '0;
      exImm      <= '0;
      exPc       <= '0;
      exAluOp    <= '0;
      exAluSrc   <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
      exRegWrite <= 1'b0;
      exMemToReg <= 1'b0;
      exBranch   <= 1'b0;
    end else if (!memHold) begin
      if (flush || load_use) begin
        // Bubble: every field cleared so nothing stale reaches EX.
        exValid    <= 1'b0;
        exRs1      <= '0;
        exRs2      <= '0;
        exRd       <= '0;
        exRs1Data  <= '0;
        exRs2Data  <= '0;
        exImm      <= '0;
        exPc       <= '0;
        exAluOp    <= '0;
        exAluSrc   <= 1'b0;
        exMemRead  <= 1'b0;
        exMemWrite <= 1'b0;
        exRegWrite <= 1'b0;
        exMemToReg <= 1'b0;
        exBranch   <= 1'b0;
      end else begin
        exValid    <= idValid;
        exRs1      <= idRs1;
        exRs2      <= idRs2;
        exRd       <= idRd;
        exRs1Data  <= idRs1Data;
        exRs2Data  <= idRs2Data;
        exImm      <= idImm;
        exPc       <= idPc;
        exAluOp    <= idAluOp;
        exAluSrc   <= idAluSrc;
        exMemRead  <= idMemRead;
        exMemWrite <= idMemWrite;
        exRegWrite <= idRegWrite;
        exMemToReg <= idMemToReg;
        exBranch   <= idBranch;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Flush has priority over loadUse, so a cycle with both counts as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbleCount <= '0;
      flushCount  <= '0;
    end else if (!memHold) begin
      if (flush) begin
        if (flushCount != 32'hFFFF_FFFF) flushCount <= flushCount + 32'd1;
      end else if (load_use) begin
        if (bubbleCount != 32'hFFFF_FFFF) bubbleCount <= bubbleCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed bench for id_ex_stage_reg. Inputs change on the falling edge,
//   stallIfId is sampled 1 ns later, and registered outputs are sampled
//   1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;

  logic               clk;
  logic               rst_n;
  logic               memHold;
  logic               flush;
  logic               idValid;
  logic [4:0]         idRs1, idRs2, idRd;
  logic               idUsesRs1, idUsesRs2;
  logic [XLEN-1:0]    idRs1Data, idRs2Data, idImm, idPc;
  logic [ALUOP_W-1:0] idAluOp;
  logic               idAluSrc, idMemRead, idMemWrite, idRegWrite, idMemToReg, idBranch;
  logic               exValid;
  logic [4:0]         exRs1, exRs2, exRd;
  logic [XLEN-1:0]    exRs1Data, exRs2Data, exImm, exPc;
  logic [ALUOP_W-1:0] exAluOp;
  logic               exAluSrc, exMemRead, exMemWrite, exRegWrite, exMemToReg, exBranch;
  logic               stallIfId;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]        bubbleCount, flushCount;
`endif

  int total;
  int bad;
  logic [XLEN-1:0] exp_q[$];

  id_ex_stage_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .memHold(memHold), .flush(flush),
    .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm), .idPc(idPc),
    .idAluOp(idAluOp), .idAluSrc(idAluSrc), .idMemRead(idMemRead),
    .idMemWrite(idMemWrite), .idRegWrite(idRegWrite), .idMemToReg(idMemToReg),
    .idBranch(idBranch),
    .exValid(exValid), .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd),
    .exRs1Data(exRs1Data), .exRs2Data(exRs2Data), .exImm(exImm), .exPc(exPc),
    .exAluOp(exAluOp), .exAluSrc(exAluSrc), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exRegWrite(exRegWrite), .exMemToReg(exMemToReg),
    .exBranch(exBranch),
`ifdef HAZARD_PERF_CNT_EN
    .bubbleCount(bubbleCount), .flushCount(flushCount),
`endif
    .stallIfId(stallIfId)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID instruction. Secondary fields are derived from imm so the
  // bench can predict them: rs1Data = imm ^ 0x11110000, rs2Data = imm ^
  // 0x22220000, pc = imm << 2, aluOp = imm[3:0], aluSrc = imm[0],
  // memToReg = memRead, memWrite = 0, branch = imm[1].
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic mr, input logic rw, input logic [XLEN-1:0] imm);
    idValid    = v;
    idRs1      = rs1;
    idRs2      = rs2;
    idRd       = rd;
    idUsesRs1  = u1;
    idUsesRs2  = u2;
    idMemRead  = mr;
    idRegWrite = rw;
    idImm      = imm;
    idRs1Data  = imm ^ 32'h1111_0000;
    idRs2Data  = imm ^ 32'h2222_0000;
    idPc       = imm << 2;
    idAluOp    = imm[3:0];
    idAluSrc   = imm[0];
    idMemToReg = mr;
    idMemWrite = 1'b0;
    idBranch   = imm[1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, exValid, 1'b0);
    check({tag, ".rd"}, exRd, 5'd0);
    check({tag, ".regwrite"}, exRegWrite, 1'b0);
    check({tag, ".memread"}, exMemRead, 1'b0);
  endtask

  initial begin
    logic [XLEN-1:0] e;
    logic [XLEN-1:0] r;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    memHold = 1'b0;
    flush   = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rst0.valid", exValid, 1'b0);
    check("rst0.stall", stallIfId, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero instruction, then assert reset mid-cycle.
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00AB);
    step();
    check("pre_rst.rd", exRd, 5'd9);
    check("pre_rst.imm", exImm, 32'hAB);
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", exValid, 1'b0);
    check("rst.rd", exRd, 5'd0);
    check("rst.imm", exImm, 32'h0);
    check("rst.rs1data", exRs1Data, 32'h0);
    check("rst.memread", exMemRead, 1'b0);
    check("rst.regwrite", exRegWrite, 1'b0);
    check("rst.stall", stallIfId, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst.bubblecnt", bubbleCount, 32'd0);
    check("rst.flushcnt", flushCount, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Normal flow.
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    #1 check("norm.stall", stallIfId, 1'b0);
    step();
    check("norm.valid", exValid, 1'b1);
    check("norm.rd", exRd, 5'd5);
    check("norm.regwrite", exRegWrite, 1'b1);
    check("norm.imm", exImm, 32'h10);
    check("norm.rs1data", exRs1Data, 32'h1111_0010);

    // Load-use on rs2: load to x7 in EX, consumer reads x7 as rs2.
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30);
    step();
    check("lu.ld_memread", exMemRead, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd2, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
    #1 check("lu.stall", stallIfId, 1'b1);
    step();
    check_bubble("lu.bubble");
    // Same instruction re-presented: no stall, loads normally.
    #1 check("lu.re_stall", stallIfId, 1'b0);
    step();
    check("lu.re_valid", exValid, 1'b1);
    check("lu.re_rd", exRd, 5'd8);
    check("lu.re_rs2", exRs2, 5'd7);
    check("lu.re_imm", exImm, 32'h20);
`ifdef HAZARD_PERF_CNT_EN
    check("lu.bubblecnt", bubbleCount, 32'd1);
`endif

    // Load to x0 never stalls.
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    step();
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h41);
    #1 check("x0.stall", stallIfId, 1'b0);

    // rs1 matches a load but the instruction does not read rs1.
    step();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 32'h50);
    step();
    @(negedge clk);
    set_id(1'b1, 5'd6, 5'd6, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h51);
    #1 check("nouse.stall", stallIfId, 1'b0);
    // Invalid ID instruction reading x6 does not stall and loads invalid.
    set_id(1'b0, 5'd6, 5'd6, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h52);
    #1 check("inval.stall", stallIfId, 1'b0);
    step();
    check("inval.valid", exValid, 1'b0);

    // Flush while a load-use hazard is present.
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60);
    step();
    @(negedge clk);
    set_id(1'b1, 5'd7, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h61);
    #1 check("fl.stall_pre", stallIfId, 1'b1);
    flush = 1'b1;
    #1 check("fl.stall", stallIfId, 1'b0);
    step();
    check_bubble("fl.bubble");
`ifdef HAZARD_PERF_CNT_EN
    check("fl.flushcnt", flushCount, 32'd1);
    check("fl.bubblecnt", bubbleCount, 32'd1);
`endif
    flush = 1'b0;

    // memHold with a load to x11 in EX and a dependent instruction in ID.
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
    step();
    check("mh.ld_rd", exRd, 5'd11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memHold = 1'b1;
      flush   = (i != 2);
      set_id(1'b1, 5'd11, 5'(i + 12), 5'(i + 20), 1'b1, 1'b1, 1'b0, 1'b0,
             32'($urandom_range(32'h100, 32'hFFFF)));
      #1 check("mh.stall", stallIfId, 1'b0);
      step();
      check("mh.valid", exValid, 1'b1);
      check("mh.rd", exRd, 5'd11);
      check("mh.imm", exImm, 32'h55);
      check("mh.memread", exMemRead, 1'b1);
    end
`ifdef HAZARD_PERF_CNT_EN
    check("mh.flushcnt", flushCount, 32'd1);
    check("mh.bubblecnt", bubbleCount, 32'd1);
`endif
    // Release: the held dependency now stalls one cycle.
    @(negedge clk);
    memHold = 1'b0;
    flush   = 1'b0;
    set_id(1'b1, 5'd11, 5'd3, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77);
    #1 check("rel.stall", stallIfId, 1'b1);
    step();
    check_bubble("rel.bubble");
    step();
    check("rel.rd", exRd, 5'd13);
    check("rel.imm", exImm, 32'h77);
`ifdef HAZARD_PERF_CNT_EN
    check("rel.bubblecnt", bubbleCount, 32'd2);
`endif

    // Hazard-free stream: each instruction appears in EX one edge later.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r = 32'($urandom_range(0, 32'hFFFF)) << 8;
      set_id(1'b1, 5'd1, 5'd2, 5'(i + 1), 1'b1, 1'b1, 1'b0, 1'b1, r);
      exp_q.push_back(r);
      #1 check("str.stall", stallIfId, 1'b0);
      step();
      e = exp_q.pop_front();
      check("str.imm", exImm, e);
      check("str.rs1data", exRs1Data, e ^ 32'h1111_0000);
      check("str.rs2data", exRs2Data, e ^ 32'h2222_0000);
      check("str.pc", exPc, e << 2);
      check("str.aluop", exAluOp, e[3:0]);
      check("str.branch", exBranch, e[1]);
      check("str.rd", exRd, 5'(i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
